// File: rtl/serdes_pkg.sv
// Shared definitions for the output serializer family: TMDS control tokens
// and a constant-safe ceiling log2 used to size counters.
package serdes_pkg;

    localparam logic [9:0] CTL0 = 10'h354;
    localparam logic [9:0] CTL1 = 10'h0AB;
    localparam logic [9:0] CTL2 = 10'h154;
    localparam logic [9:0] CTL3 = 10'h2AB;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gearbox_lane.sv
// One lane of the gearbox: loads a whole word (optionally bit-reversed) and
// shifts it out OUT_W bits per beat from the low end.
module gearbox_lane #(
    parameter int IN_W      = 10,
    parameter int OUT_W     = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [IN_W-1:0]  word,
    output logic [OUT_W-1:0] beat
);

    logic [IN_W-1:0] word_ord;
    logic [IN_W-1:0] sh_q;

    // Reversing on load keeps the shift path identical for both bit orders.
    always_comb begin
        word_ord = word;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < IN_W; i++) begin
                word_ord[i] = word[IN_W-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (!en) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= word_ord;
        end else begin
            sh_q <= sh_q >> OUT_W;
        end
    end

    assign beat = sh_q[OUT_W-1:0];

endmodule

// File: rtl/oserdes_gearbox_nch.sv
// N-lane parallel-to-narrow gearbox with a one-word skid buffer, idle-word
// fill on underflow, word-boundary strobe and a saturating underflow counter.
module oserdes_gearbox_nch
    import serdes_pkg::*;
#(
    parameter int CH        = 3,
    parameter int IN_W      = 10,
    parameter int OUT_W     = 2,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic                pclk,
    input  logic                txrst_n,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*IN_W-1:0]  in_data,
    input  logic [CH*IN_W-1:0]  idle_word,
    output logic [CH*OUT_W-1:0] tx_data,
    output logic                tx_sof,
    output logic                underflow,
    output logic [CNT_W-1:0]    underflow_cnt,
    input  logic                clr_cnt
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int BEAT_W = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(RATIO - 1);

    if (IN_W % OUT_W != 0) begin : g_ratio_check
        $error("IN_W must be a multiple of OUT_W");
    end

    logic [BEAT_W-1:0]   beat_q;
    logic                hold_v;
    logic [CH*IN_W-1:0]  hold_q;
    logic [CH*IN_W-1:0]  load_word;
    logic                load;
    logic                accept;
    logic                starve;

    // Handshake: in_ready is high when the skid slot is empty or is being
    // drained on this edge; a transfer happens on the edge where
    // in_valid & in_ready, and in_valid may not be withdrawn before it.
    assign load      = en & (beat_q == LAST);
    assign in_ready  = ~hold_v | load;
    assign accept    = in_valid & in_ready;
    assign starve    = load & ~hold_v;
    assign load_word = hold_v ? hold_q : idle_word;

    // On a simultaneous accept and load, the old word leaves through
    // load_word while the new one takes its place.
    always_ff @(posedge pclk or negedge txrst_n) begin
        if (!txrst_n) begin
            hold_q <= '0;
            hold_v <= 1'b0;
        end else if (accept) begin
            hold_q <= in_data;
            hold_v <= 1'b1;
        end else if (load) begin
            hold_v <= 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge txrst_n) begin
        if (!txrst_n) begin
            beat_q    <= LAST;
            tx_sof    <= 1'b0;
            underflow <= 1'b0;
        end else if (!en) begin
            beat_q    <= LAST;
            tx_sof    <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            beat_q    <= '0;
            tx_sof    <= 1'b1;
            underflow <= ~hold_v;
        end else begin
            beat_q    <= beat_q + BEAT_W'(1);
            tx_sof    <= 1'b0;
            underflow <= 1'b0;
        end
    end

    // Counts on the same edge that raises the underflow pulse.
    always_ff @(posedge pclk or negedge txrst_n) begin
        if (!txrst_n) begin
            underflow_cnt <= '0;
        end else if (clr_cnt) begin
            underflow_cnt <= '0;
        end else if (starve && (underflow_cnt != '1)) begin
            underflow_cnt <= underflow_cnt + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        gearbox_lane #(
            .IN_W     (IN_W),
            .OUT_W    (OUT_W),
            .MSB_FIRST(MSB_FIRST)
        ) u_lane (
            .clk  (pclk),
            .rst_n(txrst_n),
            .en   (en),
            .load (load),
            .word (load_word[k*IN_W +: IN_W]),
            .beat (tx_data[k*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_oserdes_gearbox_nch.sv
// Bench for oserdes_gearbox_nch: two single-lane 10:2 instances (LSB-first with
// a 16-bit counter, MSB-first with a 2-bit counter) driven by shared inputs.
module tb_oserdes_gearbox_nch;
    import serdes_pkg::*;

    // ---------------- clock / reset ----------------
    logic        pclk = 1'b0;
    logic        txrst_n;
    logic        en;
    logic        in_valid;
    logic        clr_cnt;
    logic [9:0]  in_data;
    logic [9:0]  idle_word;
    logic        ready0, ready1;
    logic [1:0]  tx0, tx1;
    logic        sof0, sof1, uf0, uf1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 pclk = ~pclk;

    oserdes_gearbox_nch #(.CH(1), .IN_W(10), .OUT_W(2), .MSB_FIRST(0), .CNT_W(16)) dut0 (
        .pclk(pclk), .txrst_n(txrst_n), .en(en), .in_valid(in_valid), .in_ready(ready0),
        .in_data(in_data), .idle_word(idle_word), .tx_data(tx0), .tx_sof(sof0),
        .underflow(uf0), .underflow_cnt(cnt0), .clr_cnt(clr_cnt)
    );

    oserdes_gearbox_nch #(.CH(1), .IN_W(10), .OUT_W(2), .MSB_FIRST(1), .CNT_W(2)) dut1 (
        .pclk(pclk), .txrst_n(txrst_n), .en(en), .in_valid(in_valid), .in_ready(ready1),
        .in_data(in_data), .idle_word(idle_word), .tx_data(tx1), .tx_sof(sof1),
        .underflow(uf1), .underflow_cnt(cnt1), .clr_cnt(clr_cnt)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        txrst_n   = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        in_data   = '0;
        idle_word = CTL0;
        repeat (2) @(negedge pclk);
        txrst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic [9:0] exp_q[$];
    logic [9:0] m_word;
    int         m_idx;
    bit         m_act, m_sof, m_uf, m_ready;
    int         m_cnt0, m_cnt1;

    function automatic logic [1:0] beat_of(input logic [9:0] w, input int idx, input bit msb);
        logic [9:0] ww;
        ww = w;
        if (msb) for (int i = 0; i < 10; i++) ww[i] = w[9-i];
        return 2'((ww >> (2 * idx)) & 10'd3);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_word = '0; m_idx = 4; m_act = 0; m_sof = 0; m_uf = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && m_ready;
        if (en) begin
            if (m_idx == 4) begin
                if (exp_q.size() != 0) begin
                    m_word = exp_q.pop_front();
                    m_uf   = 0;
                end else begin
                    m_word = idle_word;
                    m_uf   = 1;
                end
                m_idx = 0; m_sof = 1; m_act = 1;
            end else begin
                m_idx++; m_sof = 0; m_uf = 0;
            end
        end else begin
            m_idx = 4; m_act = 0; m_sof = 0; m_uf = 0;
        end
        if (acc) exp_q.push_back(in_data);
        if (clr_cnt) begin
            m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_uf) begin
            if (m_cnt0 < 65535) m_cnt0++;
            if (m_cnt1 < 3) m_cnt1++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0]      word;
        logic [0:4][1:0] exp_lsb;
        logic [0:4][1:0] exp_msb;
    } vec_t;

    vec_t            vecs[5];
    logic [9:0]      toks[4];
    logic [9:0]      w3[3];
    logic [0:4][1:0] idle_lsb, idle_msb;
    logic [1:0]      rec_tx[40];
    bit              rec_sof[40], rec_uf[40];
    int              acc_n, lows, first, n_uf;
    bit              found, accepted;

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vecs[0] = '{10'h329, {2'b01, 2'b10, 2'b10, 2'b00, 2'b11}, {2'b11, 2'b00, 2'b01, 2'b01, 2'b10}};
        vecs[1] = '{10'h200, {2'b00, 2'b00, 2'b00, 2'b00, 2'b10}, {2'b01, 2'b00, 2'b00, 2'b00, 2'b00}};
        vecs[2] = '{10'h0F0, {2'b00, 2'b00, 2'b11, 2'b11, 2'b00}, {2'b00, 2'b11, 2'b11, 2'b00, 2'b00}};
        vecs[3] = '{10'h001, {2'b01, 2'b00, 2'b00, 2'b00, 2'b00}, {2'b00, 2'b00, 2'b00, 2'b00, 2'b10}};
        vecs[4] = '{10'h2AA, {2'b10, 2'b10, 2'b10, 2'b10, 2'b10}, {2'b01, 2'b01, 2'b01, 2'b01, 2'b01}};
        idle_lsb = {2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        idle_msb = {2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        toks = '{CTL0, CTL1, CTL2, CTL3};
        w3   = '{10'h3FF, 10'h000, 10'h2AA};

        // Reset state, then free-running idle fill.
        do_reset();
        check("rst_tx0", tx0, 0);
        check("rst_sof", sof0, 0);
        check("rst_uf", uf0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_ready", ready0, 1);
        en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            check("idle_tx0", tx0, idle_lsb[c % 5]);
            check("idle_tx1", tx1, idle_msb[c % 5]);
            check("idle_sof", sof0, (c % 5) == 0);
            check("idle_uf", uf0, (c % 5) == 0);
            check("idle_cnt", cnt0, c / 5 + 1);
        end

        // Single words from the table, both bit orders.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            en       = 1'b1;
            in_valid = 1'b1;
            in_data  = vecs[v].word;
            @(negedge pclk);
            in_valid = 1'b0;
            found = 0;
            for (int t = 0; t < 12; t++) begin
                if (sof0 && !uf0) begin
                    found = 1;
                    break;
                end
                @(negedge pclk);
            end
            check("vec_found", found, 1);
            for (int b = 0; b < 5; b++) begin
                check("vec_tx_lsb", tx0, vecs[v].exp_lsb[b]);
                check("vec_tx_msb", tx1, vecs[v].exp_msb[b]);
                check("vec_sof", sof0, b == 0);
                check("vec_uf", uf0, 0);
                @(negedge pclk);
            end
        end

        // Back-to-back words with in_valid held.
        do_reset();
        en = 1'b1; in_valid = 1'b1; in_data = w3[0];
        acc_n = 0; lows = 0;
        for (int k = 0; k < 30; k++) begin
            rec_tx[k] = tx0; rec_sof[k] = sof0; rec_uf[k] = uf0;
            if (in_valid && !ready0) lows++;
            accepted = in_valid && ready0;
            @(negedge pclk);
            if (accepted) begin
                acc_n++;
                if (acc_n == 3) in_valid = 1'b0;
                else in_data = w3[acc_n];
            end
        end
        check("b2b_accepts", acc_n, 3);
        check("b2b_ready_lows", lows, 8);
        first = -1;
        for (int k = 0; k < 30; k++) begin
            if (first < 0 && rec_sof[k] && !rec_uf[k]) first = k;
        end
        check("b2b_found", first >= 0, 1);
        if (first >= 0 && first + 15 <= 30) begin
            for (int j = 0; j < 15; j++)
                check("b2b_tx", rec_tx[first+j], beat_of(w3[j/5], j % 5, 0));
            for (int j = 0; j < 3; j++) begin
                check("b2b_sof", rec_sof[first+5*j], 1);
                check("b2b_uf", rec_uf[first+5*j], 0);
            end
        end

        // Pre-load with en low, then reset in the middle of the word.
        do_reset();
        in_valid = 1'b1; in_data = 10'h1C7;
        @(negedge pclk);
        in_valid = 1'b0;
        check("pre_ready", ready0, 0);
        check("pre_tx", tx0, 0);
        check("pre_sof", sof0, 0);
        en = 1'b1;
        @(negedge pclk);
        check("pre_sof_first", sof0, 1);
        check("pre_uf_first", uf0, 0);
        check("pre_beat0", tx0, 2'b11);
        @(negedge pclk);
        check("pre_beat1", tx0, 2'b01);
        #2;
        txrst_n = 1'b0;
        en      = 1'b0;
        #1;
        check("midrst_tx", tx0, 0);
        check("midrst_sof", sof0, 0);
        check("midrst_hold_empty", ready0, 1);
        @(negedge pclk);
        txrst_n = 1'b1;

        // Counter saturation and clear colliding with an underflow.
        do_reset();
        en = 1'b1; n_uf = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge pclk);
            if (uf1) n_uf++;
        end
        check("sat_pulses", n_uf, 5);
        check("sat_cnt1", cnt1, 3);
        check("sat_cnt0", cnt0, 5);
        clr_cnt = 1'b1;
        @(negedge pclk);
        clr_cnt = 1'b0;
        check("clr_uf_same_edge", uf1, 1);
        check("clr_cnt1", cnt1, 0);
        check("clr_cnt0", cnt0, 0);
        @(negedge pclk);
        check("clr_cnt1_hold", cnt1, 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en        = ($urandom_range(0, 15) != 0);
            in_valid  = (cyc % 400 < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            in_data   = 10'($urandom_range(0, 1023));
            clr_cnt   = ($urandom_range(0, 63) == 0);
            idle_word = toks[$urandom_range(0, 3)];
            #1;
            m_ready = (exp_q.size() == 0) || (en && m_idx == 4);
            check("rnd_ready0", ready0, m_ready);
            check("rnd_ready1", ready1, m_ready);
            check("rnd_tx0", tx0, m_act ? beat_of(m_word, m_idx, 0) : 2'b00);
            check("rnd_tx1", tx1, m_act ? beat_of(m_word, m_idx, 1) : 2'b00);
            check("rnd_sof", sof0, m_sof);
            check("rnd_uf", uf0, m_uf);
            check("rnd_sof1", sof1, m_sof);
            check("rnd_cnt0", cnt0, m_cnt0);
            check("rnd_cnt1", cnt1, m_cnt1);
            model_step();
            @(negedge pclk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
